// File: rtl/e203_exu_fregfile_wbarb_if.sv
// Writeback bus between the FP writeback requesters, the arbiter and the
// FP regfile write port. The three requesters are packed side by side:
// requester i sits at [i*RFIDX_W +: RFIDX_W] in req_idx and [i*DW +: DW] in req_dat.
interface e203_exu_fregfile_wbarb_if #(
  parameter int RFIDX_W = 5,
  parameter int DW      = 32
);

  logic [2:0]           req_valid;
  logic [2:0]           req_ready;
  logic [3*RFIDX_W-1:0] req_idx;
  logic [3*DW-1:0]      req_dat;

  logic                 wbck_dest_wen;
  logic [RFIDX_W-1:0]   wbck_dest_idx;
  logic [DW-1:0]        wbck_dest_dat;

  // Writeback sources and the regfile side
  modport master (
    output req_valid,
    output req_idx,
    output req_dat,
    input  req_ready,
    input  wbck_dest_wen,
    input  wbck_dest_idx,
    input  wbck_dest_dat
  );

  // The arbiter
  modport slave (
    input  req_valid,
    input  req_idx,
    input  req_dat,
    output req_ready,
    output wbck_dest_wen,
    output wbck_dest_idx,
    output wbck_dest_dat
  );

endinterface

// File: rtl/e203_exu_fregfile_wbarb.sv
// FP regfile write-port arbiter and pending-destination scoreboard.
// Three writeback requesters (0=FPU pipe, 1=LSU FP load, 2=int->FP move)
// share a single registered write port. The scoreboard tracks FP
// destinations allocated at dispatch and flags RAW/WAW hazards.
// Optional feature macro: E203_FWBARB_RR_EN selects round-robin
// arbitration; when undefined the arbiter is fixed priority 0 > 1 > 2
// and requester 2 can starve.
module e203_exu_fregfile_wbarb #(
  parameter int RFIDX_W = 5,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  e203_exu_fregfile_wbarb_if.slave bus,

  input  logic                 issue_valid,
  input  logic [RFIDX_W-1:0]   issue_idx,
  output logic                 issue_ready,

  input  logic [RFIDX_W-1:0]   chk_idx1,
  input  logic [RFIDX_W-1:0]   chk_idx2,
  input  logic [RFIDX_W-1:0]   chk_idx3,
  output logic                 dep_src1,
  output logic                 dep_src2,
  output logic                 dep_src3
);

  localparam int NREG = 1 << RFIDX_W;

  logic [2:0]         grant;
  logic [RFIDX_W-1:0] sel_idx;
  logic [DW-1:0]      sel_dat;

  logic               wen_r;
  logic [RFIDX_W-1:0] idx_r;
  logic [DW-1:0]      dat_r;
  logic               wbck_wen;

  logic [NREG-1:0]    pend;
  logic [NREG-1:0]    pend_nxt;
  logic               issue_fire;

`ifdef E203_FWBARB_RR_EN
  // rr_ptr names the requester searched first; it only ever holds 0..2
  logic [1:0] rr_ptr;
  logic [1:0] rr_ptr_nxt;

  // Round-robin grant starting the search at rr_ptr; nothing is granted in reset
  always_comb begin
    grant = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (bus.req_valid[1])      grant = 3'b010;
        else if (bus.req_valid[2]) grant = 3'b100;
        else if (bus.req_valid[0]) grant = 3'b001;
      end
      2'd2: begin
        if (bus.req_valid[2])      grant = 3'b100;
        else if (bus.req_valid[0]) grant = 3'b001;
        else if (bus.req_valid[1]) grant = 3'b010;
      end
      default: begin
        if (bus.req_valid[0])      grant = 3'b001;
        else if (bus.req_valid[1]) grant = 3'b010;
        else if (bus.req_valid[2]) grant = 3'b100;
      end
    endcase
    if (rst) grant = 3'b000;
  end

  // Pointer moves just past the requester that won, wrapping 2 -> 0
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant[0])      rr_ptr_nxt = 2'd1;
    else if (grant[1]) rr_ptr_nxt = 2'd2;
    else if (grant[2]) rr_ptr_nxt = 2'd0;
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= 2'd0;
    else     rr_ptr <= rr_ptr_nxt;
  end
`else
  // Fixed priority grant 0 > 1 > 2; nothing is granted in reset
  always_comb begin
    grant = 3'b000;
    if (bus.req_valid[0])      grant = 3'b001;
    else if (bus.req_valid[1]) grant = 3'b010;
    else if (bus.req_valid[2]) grant = 3'b100;
    if (rst) grant = 3'b000;
  end
`endif

  // The output stage never stalls, so a grant is the ready
  assign bus.req_ready = grant;

  // Select index and data of the granted requester (grant is one-hot)
  always_comb begin
    sel_idx = '0;
    sel_dat = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        sel_idx = bus.req_idx[i*RFIDX_W +: RFIDX_W];
        sel_dat = bus.req_dat[i*DW +: DW];
      end
    end
  end

  // Registered write port; idx/dat hold their value on idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_r <= 1'b0;
      idx_r <= '0;
      dat_r <= '0;
    end else begin
      wen_r <= |grant;
      if (|grant) begin
        idx_r <= sel_idx;
        dat_r <= sel_dat;
      end
    end
  end

  // A write already in the output register is dropped while reset is high
  assign wbck_wen          = wen_r & ~rst;
  assign bus.wbck_dest_wen = wbck_wen;
  assign bus.wbck_dest_idx = idx_r;
  assign bus.wbck_dest_dat = dat_r;

  // Allocation is refused while the destination is still pending (WAW)
  assign issue_ready = ~pend[issue_idx];
  assign issue_fire  = issue_valid & issue_ready;

  // Clear on regfile write, then set on allocation so a same-cycle set wins
  always_comb begin
    pend_nxt = pend;
    if (wbck_wen)   pend_nxt[idx_r]     = 1'b0;
    if (issue_fire) pend_nxt[issue_idx] = 1'b1;
  end

  // Pending-destination register
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  // RAW hazard lookup for the three sources in dispatch
  assign dep_src1 = pend[chk_idx1];
  assign dep_src2 = pend[chk_idx2];
  assign dep_src3 = pend[chk_idx3];

endmodule

// File: tb/tb_e203_exu_fregfile_wbarb.sv
// Directed self-checking bench for e203_exu_fregfile_wbarb.
// Expectations follow E203_FWBARB_RR_EN the same way the design does.
module tb_e203_exu_fregfile_wbarb;

  localparam int RFIDX_W = 5;
  localparam int DW      = 32;

  logic               clk;
  logic               rst;
  logic               issue_valid;
  logic [RFIDX_W-1:0] issue_idx;
  logic               issue_ready;
  logic [RFIDX_W-1:0] chk_idx1;
  logic [RFIDX_W-1:0] chk_idx2;
  logic [RFIDX_W-1:0] chk_idx3;
  logic               dep_src1;
  logic               dep_src2;
  logic               dep_src3;

  int checkCount;
  int passCount;

  e203_exu_fregfile_wbarb_if #(.RFIDX_W(RFIDX_W), .DW(DW)) bus ();

  e203_exu_fregfile_wbarb #(.RFIDX_W(RFIDX_W), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_ready (issue_ready),
    .chk_idx1    (chk_idx1),
    .chk_idx2    (chk_idx2),
    .chk_idx3    (chk_idx3),
    .dep_src1    (dep_src1),
    .dep_src2    (dep_src2),
    .dep_src3    (dep_src3)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Drive the requester side of the bus
  task automatic applyStimulus(input logic [2:0] valid,
                               input logic [3*RFIDX_W-1:0] idx,
                               input logic [3*DW-1:0] dat);
    bus.req_valid = valid;
    bus.req_idx   = idx;
    bus.req_dat   = dat;
  endtask

  // Move to just after the next rising edge
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle reset with all requesters idle
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(3'b000, '0, '0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  logic [2:0]           expGrant [4];
  logic [RFIDX_W-1:0]   expIdx   [4];
  logic [DW-1:0]        expDat   [4];
  logic [3*RFIDX_W-1:0] t3Idx;
  logic [3*DW-1:0]      t3Dat;

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    checkCount  = 0;
    passCount   = 0;
    issue_valid = 1'b0;
    issue_idx   = '0;
    chk_idx1    = '0;
    chk_idx2    = '0;
    chk_idx3    = '0;

    // T1: reset with every requester asking
    t3Idx = {5'd3, 5'd2, 5'd1};
    t3Dat = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    applyStimulus(3'b111, t3Idx, t3Dat);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("t1_ready", 64'(bus.req_ready), 64'h0);
    checkOutput("t1_wen", 64'(bus.wbck_dest_wen), 64'h0);
    for (int i = 0; i < 32; i++) begin
      issue_idx = RFIDX_W'(i);
      chk_idx1  = RFIDX_W'(i);
      @(negedge clk);
      checkOutput($sformatf("t1_issue_ready_%0d", i), 64'(issue_ready), 64'h1);
      checkOutput($sformatf("t1_dep_%0d", i), 64'(dep_src1), 64'h0);
    end

    // T2: single request latency
    nextCycle();
    rst = 1'b0;
    applyStimulus(3'b001, {10'd0, 5'd5}, {64'd0, 32'h3F80_0000});
    @(negedge clk);
    checkOutput("t2_ready_n", 64'(bus.req_ready), 64'h1);
    checkOutput("t2_wen_n", 64'(bus.wbck_dest_wen), 64'h0);
    nextCycle();
    applyStimulus(3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t2_wen_n1", 64'(bus.wbck_dest_wen), 64'h1);
    checkOutput("t2_idx_n1", 64'(bus.wbck_dest_idx), 64'd5);
    checkOutput("t2_dat_n1", 64'(bus.wbck_dest_dat), 64'h3F80_0000);
    nextCycle();
    @(negedge clk);
    checkOutput("t2_wen_n2", 64'(bus.wbck_dest_wen), 64'h0);
    checkOutput("t2_idx_hold", 64'(bus.wbck_dest_idx), 64'd5);
    checkOutput("t2_dat_hold", 64'(bus.wbck_dest_dat), 64'h3F80_0000);
    checkOutput("t2_ready_idle", 64'(bus.req_ready), 64'h0);

    // T3: all three requesters held valid
    resetDut();
`ifdef E203_FWBARB_RR_EN
    expGrant = '{3'b001, 3'b010, 3'b100, 3'b001};
    expIdx   = '{5'd1, 5'd2, 5'd3, 5'd1};
    expDat   = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h1111_0001};
`else
    expGrant = '{3'b001, 3'b001, 3'b001, 3'b001};
    expIdx   = '{5'd1, 5'd1, 5'd1, 5'd1};
    expDat   = '{32'h1111_0001, 32'h1111_0001, 32'h1111_0001, 32'h1111_0001};
`endif
    applyStimulus(3'b111, t3Idx, t3Dat);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t3_grant_%0d", c), 64'(bus.req_ready), 64'(expGrant[c]));
      if (c > 0) begin
        checkOutput($sformatf("t3_idx_%0d", c), 64'(bus.wbck_dest_idx), 64'(expIdx[c-1]));
        checkOutput($sformatf("t3_dat_%0d", c), 64'(bus.wbck_dest_dat), 64'(expDat[c-1]));
      end
      nextCycle();
    end
    applyStimulus(3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t3_idx_last", 64'(bus.wbck_dest_idx), 64'(expIdx[3]));

    // T4: allocate idx 7, then requester 1 writes it back
    nextCycle();
    issue_valid = 1'b1;
    issue_idx   = 5'd7;
    chk_idx1    = 5'd7;
    chk_idx2    = 5'd8;
    chk_idx3    = 5'd7;
    @(negedge clk);
    checkOutput("t4_issue_ready_n", 64'(issue_ready), 64'h1);
    checkOutput("t4_dep1_n", 64'(dep_src1), 64'h0);
    nextCycle();
    issue_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_issue_ready_n1", 64'(issue_ready), 64'h0);
    checkOutput("t4_dep1_n1", 64'(dep_src1), 64'h1);
    checkOutput("t4_dep2_n1", 64'(dep_src2), 64'h0);
    checkOutput("t4_dep3_n1", 64'(dep_src3), 64'h1);
    nextCycle();
    applyStimulus(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0});
    @(negedge clk);
    checkOutput("t4_ready_m", 64'(bus.req_ready), 64'h2);
    checkOutput("t4_dep1_m", 64'(dep_src1), 64'h1);
    nextCycle();
    applyStimulus(3'b000, '0, '0);
    @(negedge clk);
    checkOutput("t4_wen_m1", 64'(bus.wbck_dest_wen), 64'h1);
    checkOutput("t4_idx_m1", 64'(bus.wbck_dest_idx), 64'd7);
    checkOutput("t4_dat_m1", 64'(bus.wbck_dest_dat), 64'hDEAD_BEEF);
    checkOutput("t4_dep1_m1", 64'(dep_src1), 64'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_dep1_m2", 64'(dep_src1), 64'h0);
    checkOutput("t4_issue_ready_m2", 64'(issue_ready), 64'h1);

    // T5: writeback to idx 9 in the same cycle idx 9 is allocated
    nextCycle();
    applyStimulus(3'b001, {10'd0, 5'd9}, {64'd0, 32'h0000_0909});
    chk_idx1 = 5'd9;
    nextCycle();
    applyStimulus(3'b000, '0, '0);
    issue_valid = 1'b1;
    issue_idx   = 5'd9;
    @(negedge clk);
    checkOutput("t5_wen_n", 64'(bus.wbck_dest_wen), 64'h1);
    checkOutput("t5_idx_n", 64'(bus.wbck_dest_idx), 64'd9);
    checkOutput("t5_issue_ready_n", 64'(issue_ready), 64'h1);
    nextCycle();
    issue_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_dep1_n1", 64'(dep_src1), 64'h1);
    checkOutput("t5_issue_ready_n1", 64'(issue_ready), 64'h0);

    // T6: reset arrives the cycle after a grant and an allocation
    nextCycle();
    applyStimulus(3'b001, {10'd0, 5'd4}, {64'd0, 32'h0000_0404});
    issue_valid = 1'b1;
    issue_idx   = 5'd3;
    @(negedge clk);
    checkOutput("t6_ready_n", 64'(bus.req_ready), 64'h1);
    checkOutput("t6_issue_ready_n", 64'(issue_ready), 64'h1);
    nextCycle();
    rst = 1'b1;
    applyStimulus(3'b000, '0, '0);
    issue_valid = 1'b0;
    @(negedge clk);
    checkOutput("t6_wen_n1", 64'(bus.wbck_dest_wen), 64'h0);
    nextCycle();
    rst      = 1'b0;
    chk_idx1 = 5'd3;
    chk_idx2 = 5'd4;
    chk_idx3 = 5'd9;
    @(negedge clk);
    checkOutput("t6_wen_n2", 64'(bus.wbck_dest_wen), 64'h0);
    checkOutput("t6_dep1", 64'(dep_src1), 64'h0);
    checkOutput("t6_dep2", 64'(dep_src2), 64'h0);
    checkOutput("t6_dep3", 64'(dep_src3), 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
